seg7_mode_sequencer: RTL and testbench
======================================

Name: seg7_mode_sequencer

Overview:
- Drives NUM_DIGITS seven-segment digits from two mode switches.
- Adds timed sequential behaviour: a prescaled step tick, a marching-digit pattern in either direction, a BCD up-counter, and a pause mode.
- Sits between the board switches and the seven-segment pins.
- Segment encoding is internal to this block; no external decoder.

Parameters:
- NUM_DIGITS, 3, number of seven-segment digits driven (legal range 2..8).
- TICK_DIV, 25000000, clk cycles per step tick (1 Hz at 25 MHz); minimum 2.
- CNT_W, 25, prescaler width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- clk  input  1  system clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- sw1  input  1  mode switch, MSB; asynchronous to clk.
- sw0  input  1  mode switch, LSB; asynchronous to clk.
- seg7  output  7*NUM_DIGITS  segments. Digit k occupies bits [7k+6:7k]; bit 0 = a … bit 6 = g; active-low. Digit 0 is rightmost.
- seg7_dpt  output  NUM_DIGITS  decimal points, bit k = digit k, active-low.
- tick  output  1  one-cycle pulse on each accepted step.

Behaviour:
- Reset (async assert, sync release): prescaler=0, pos=0, bcd=all 0, mode_q=00, sync flops=0, seg7 all 1 (blank), seg7_dpt all 1, tick=0.
- Switch sync: {sw1,sw0} pass through a 2-flop synchronizer to give mode.
- Mode-change detect: when mode != mode_q, then on that cycle:
  - mode_q<=mode, prescaler<=0, no tick.
  - pos<=NUM_DIGITS-1 if new mode=01, else pos<=0.
  - bcd unchanged.
- Mode-change precedence: a mode change in the same cycle as a prescaler terminal count wins; that tick is discarded.
- Prescaler: counts 0..TICK_DIV-1 in modes 01/10/11. At TICK_DIV-1 it wraps to 0 and asserts tick for one cycle. In mode 00 it is held at 0 and tick=0.
- Mode 00 (PAUSE):
  - pos and bcd frozen.
  - Displayed digits keep the content of the last non-pause mode. After reset, that content is bcd.
  - All dpts on (0).
- Mode 01 (MARCH_RIGHT):
  - Digit pos shows '8'; all other digits blank.
  - On tick, pos decrements; wraps 0 -> NUM_DIGITS-1.
  - dpt on only at digit pos.
- Mode 10 (MARCH_LEFT):
  - Same display as mode 01.
  - On tick, pos increments; wraps NUM_DIGITS-1 -> 0.
- Mode 11 (COUNT):
  - bcd is NUM_DIGITS decimal digits, each 4 bits, range 0..9.
  - On tick, bcd increments with decimal carry. All-9s wraps to all-0s.
  - Each digit shows its decimal value; no leading-zero blanking; all dpts off.
- Output latency: seg7/seg7_dpt are registered and reflect state one cycle after a state update. Switch edge to display change is ≤3 cycles (2 sync + 1 output register).
- Segment codes (g..a, active-low):
  - 0=40h, 1=79h, 2=24h, 3=30h, 4=19h
  - 5=12h, 6=02h, 7=78h, 8=00h, 9=10h
  - blank=7Fh
- Any BCD nibble value >9 is impossible by construction. The decoder default is blank.
- Reset mid-operation: everything returns to reset values immediately, regardless of clk.

Test Plan:
- Reset, then hold 00 → seg7 = 40h on every digit after ≤3 cycles, seg7_dpt=111, tick never asserts.
- Mode 10, NUM_DIGITS=3, TICK_DIV=4 → pos sequence 0,1,2,0. Each tick one cycle wide, 4 cycles apart. Lit digit shows 00h with its dpt=0; others 7Fh.
- Mode 01 → pos sequence starts 2 then 1,0,2. Switch to 10 mid-count → prescaler restarts, pos=0, no tick in the change cycle.
- Mode 11, TICK_DIV=2, 1000 ticks (NUM_DIGITS=3) → display reads 998,999,000 across the wrap. Digit0 at 999 shows 10h.
- Count to 042, switch to 00 → display frozen at 042, all dpt=0, no tick. Switch back to 11 → resumes 043 after TICK_DIV cycles.
- Assert rst_n low mid-count between clk edges → outputs blank and tick=0 immediately. After release, counting restarts from 000.

Source files
------------

// File: rtl/seg7_mode_sequencer.sv
// Seven-segment mode sequencer: synchronised mode switches select pause, marching
// digit (right/left) or a BCD up-counter, all stepped by a prescaled tick.
module seg7_mode_sequencer #(
    parameter int NUM_DIGITS = 3,
    parameter int TICK_DIV   = 25000000,
    parameter int CNT_W      = 25
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sw1,
    input  logic                    sw0,
    output logic [7*NUM_DIGITS-1:0] seg7,
    output logic [NUM_DIGITS-1:0]   seg7_dpt,
    output logic                    tick
);

    localparam int                POS_W     = $clog2(NUM_DIGITS);
    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [6:0]        SEG_BLANK = 7'h7F;
    localparam logic [6:0]        SEG_EIGHT = 7'h00;

    typedef enum logic [1:0] {
        MODE_PAUSE = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_LEFT  = 2'b10,
        MODE_COUNT = 2'b11
    } mode_t;

    // Active-low g..a pattern for one decimal digit; out-of-range shows blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

    logic [1:0]              r_sync1;
    logic [1:0]              r_sync2;
    mode_t                   r_mode_q;
    mode_t                   r_last;
    logic [CNT_W-1:0]        r_cnt;
    logic [POS_W-1:0]        r_pos;
    logic [4*NUM_DIGITS-1:0] r_bcd;

    mode_t                   w_mode;
    mode_t                   w_mode_n;
    mode_t                   w_last_n;
    mode_t                   w_view;
    logic                    w_mode_chg;
    logic                    w_term;
    logic                    w_tick_n;
    logic [CNT_W-1:0]        w_cnt_n;
    logic [POS_W-1:0]        w_pos_n;
    logic [4*NUM_DIGITS-1:0] w_bcd_n;
    logic [4*NUM_DIGITS-1:0] w_bcd_inc;
    logic [7*NUM_DIGITS-1:0] w_seg;
    logic [NUM_DIGITS-1:0]   w_dpt_view;
    logic [NUM_DIGITS-1:0]   w_dpt;

    assign w_mode     = mode_t'(r_sync2);
    assign w_mode_chg = (w_mode != r_mode_q);
    assign w_term     = (r_cnt == CNT_LAST);

    // Decimal ripple-carry increment of the BCD counter, all-9s wrapping to zero.
    always_comb begin
        logic carry;
        w_bcd_inc = r_bcd;
        carry     = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (carry) begin
                if (r_bcd[4*k +: 4] == 4'd9) begin
                    w_bcd_inc[4*k +: 4] = 4'd0;
                end else begin
                    w_bcd_inc[4*k +: 4] = r_bcd[4*k +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end else begin
                w_bcd_inc[4*k +: 4] = r_bcd[4*k +: 4];
            end
        end
    end

    // Next-state: a mode change restarts the prescaler and beats a coincident terminal count.
    always_comb begin
        w_mode_n = r_mode_q;
        w_cnt_n  = r_cnt;
        w_pos_n  = r_pos;
        w_bcd_n  = r_bcd;
        w_tick_n = 1'b0;
        if (w_mode_chg) begin
            w_mode_n = w_mode;
            w_cnt_n  = '0;
            w_pos_n  = (w_mode == MODE_RIGHT) ? POS_LAST : '0;
        end else if (r_mode_q == MODE_PAUSE) begin
            w_cnt_n = '0;
        end else if (w_term) begin
            w_cnt_n  = '0;
            w_tick_n = 1'b1;
            case (r_mode_q)
                MODE_RIGHT: w_pos_n = (r_pos == '0) ? POS_LAST : r_pos - POS_W'(1);
                MODE_LEFT:  w_pos_n = (r_pos == POS_LAST) ? '0 : r_pos + POS_W'(1);
                MODE_COUNT: w_bcd_n = w_bcd_inc;
                default:    w_bcd_n = r_bcd;
            endcase
        end else begin
            w_cnt_n = r_cnt + CNT_W'(1);
        end
        w_last_n = (w_mode_n != MODE_PAUSE) ? w_mode_n : r_last;
    end

    // Pause replays the last running mode's view; before any run that view is the counter.
    always_comb begin
        w_view     = (w_mode_n == MODE_PAUSE) ? w_last_n : w_mode_n;
        w_seg      = '1;
        w_dpt_view = '1;
        case (w_view)
            MODE_RIGHT, MODE_LEFT: begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (POS_W'(k) == w_pos_n) begin
                        w_seg[7*k +: 7] = SEG_EIGHT;
                        w_dpt_view[k]   = 1'b0;
                    end else begin
                        w_seg[7*k +: 7] = SEG_BLANK;
                        w_dpt_view[k]   = 1'b1;
                    end
                end
            end
            MODE_COUNT, MODE_PAUSE: begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    w_seg[7*k +: 7] = seg_decode(w_bcd_n[4*k +: 4]);
                end
            end
            default: begin
                w_seg      = '1;
                w_dpt_view = '1;
            end
        endcase
    end

    assign w_dpt = ((w_mode_n == MODE_PAUSE) && (w_last_n != MODE_PAUSE)) ? '0 : w_dpt_view;

    // State, synchroniser and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 2'b00;
            r_sync2  <= 2'b00;
            r_mode_q <= MODE_PAUSE;
            r_last   <= MODE_PAUSE;
            r_cnt    <= '0;
            r_pos    <= '0;
            r_bcd    <= '0;
            seg7     <= '1;
            seg7_dpt <= '1;
            tick     <= 1'b0;
        end else begin
            r_sync1  <= {sw1, sw0};
            r_sync2  <= r_sync1;
            r_mode_q <= w_mode_n;
            r_last   <= w_last_n;
            r_cnt    <= w_cnt_n;
            r_pos    <= w_pos_n;
            r_bcd    <= w_bcd_n;
            seg7     <= w_seg;
            seg7_dpt <= w_dpt;
            tick     <= w_tick_n;
        end
    end

endmodule

// File: tb/tb_seg7_mode_sequencer.sv
// Directed bench for seg7_mode_sequencer with NUM_DIGITS=3 and a 4-cycle step tick.
module tb_seg7_mode_sequencer;

    localparam int ND = 3;
    localparam int TD = 4;
    localparam int CW = 3;

    logic            clk;
    logic            rst_n;
    logic            sw1;
    logic            sw0;
    logic [7*ND-1:0] seg7;
    logic [ND-1:0]   seg7_dpt;
    logic            tick;

    int checks = 0;
    int errors = 0;
    int n;
    int ticks;

    seg7_mode_sequencer #(.NUM_DIGITS(ND), .TICK_DIV(TD), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw1      (sw1),
        .sw0      (sw0),
        .seg7     (seg7),
        .seg7_dpt (seg7_dpt),
        .tick     (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [7*ND-1:0] cnt_disp(input int v);
        return {seg_ref((v / 100) % 10), seg_ref((v / 10) % 10), seg_ref(v % 10)};
    endfunction

    function automatic logic [7*ND-1:0] march_disp(input int p);
        logic [7*ND-1:0] r;
        for (int k = 0; k < ND; k++) r[7*k +: 7] = (k == p) ? 7'h00 : 7'h7F;
        return r;
    endfunction

    function automatic logic [ND-1:0] march_dpt(input int p);
        logic [ND-1:0] r;
        r    = '1;
        r[p] = 1'b0;
        return r;
    endfunction

    task automatic wait_tick(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (tick !== 1'b1 && cyc < budget);
    endtask

    task automatic run_ticks(input int cnt);
        int c;
        for (int i = 0; i < cnt; i++) begin
            wait_tick(16, c);
            check_eq("tick_period", c, TD);
        end
    endtask

    task automatic count_ticks(input int cyc);
        for (int i = 0; i < cyc; i++) begin
            @(negedge clk);
            if (tick === 1'b1) ticks++;
        end
    endtask

    initial begin
        {sw1, sw0} = 2'b00;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        @(negedge clk);
        check_eq("reset_seg", seg7, 21'h1FFFFF);
        check_eq("reset_dpt", seg7_dpt, 3'b111);
        check_eq("reset_tick", tick, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Pause straight out of reset shows the zero counter, no dpts, no ticks.
        ticks = 0;
        count_ticks(3);
        check_eq("pause0_seg", seg7, cnt_disp(0));
        check_eq("pause0_dpt", seg7_dpt, 3'b111);
        count_ticks(10);
        check_eq("pause0_ticks", ticks, 0);

        // March left: 0,1,2,0
        {sw1, sw0} = 2'b10;
        repeat (3) @(negedge clk);
        check_eq("left_seg0", seg7, march_disp(0));
        check_eq("left_dpt0", seg7_dpt, march_dpt(0));
        check_eq("left_tick0", tick, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            wait_tick(16, n);
            check_eq("left_period", n, TD);
            check_eq("left_seg", seg7, march_disp(i % ND));
            check_eq("left_dpt", seg7_dpt, march_dpt(i % ND));
        end

        // March right: 2,1,0,2
        {sw1, sw0} = 2'b01;
        repeat (3) @(negedge clk);
        check_eq("right_seg2", seg7, march_disp(2));
        check_eq("right_dpt2", seg7_dpt, march_dpt(2));
        for (int i = 1; i <= 3; i++) begin
            wait_tick(16, n);
            check_eq("right_period", n, TD);
            check_eq("right_seg", seg7, march_disp((ND - 1 + 2 * ND - i) % ND));
        end

        // Mode change lands on the same edge as a terminal count: no tick, pos=0.
        @(negedge clk);
        check_eq("tick_width", tick, 1'b0);
        {sw1, sw0} = 2'b10;
        ticks = 0;
        count_ticks(4);
        check_eq("chg_no_tick", ticks, 0);
        check_eq("chg_seg", seg7, march_disp(0));
        check_eq("chg_dpt", seg7_dpt, march_dpt(0));
        wait_tick(16, n);
        check_eq("chg_restart", n, 3);
        check_eq("chg_seg1", seg7, march_disp(1));

        // Count up to 042
        {sw1, sw0} = 2'b11;
        repeat (3) @(negedge clk);
        check_eq("count_seg0", seg7, cnt_disp(0));
        check_eq("count_dpt", seg7_dpt, 3'b111);
        run_ticks(42);
        check_eq("count_042", seg7, cnt_disp(42));
        check_eq("count_digit1_is_4", seg7[13:7], 7'h19);

        // Pause freezes 042 with all dpts lit
        {sw1, sw0} = 2'b00;
        ticks = 0;
        count_ticks(3);
        check_eq("pause_seg", seg7, cnt_disp(42));
        check_eq("pause_dpt", seg7_dpt, 3'b000);
        count_ticks(10);
        check_eq("pause_ticks", ticks, 0);
        check_eq("pause_hold", seg7, cnt_disp(42));

        // Resume counting
        {sw1, sw0} = 2'b11;
        repeat (3) @(negedge clk);
        check_eq("resume_seg", seg7, cnt_disp(42));
        check_eq("resume_dpt", seg7_dpt, 3'b111);
        wait_tick(16, n);
        check_eq("resume_period", n, TD);
        check_eq("resume_043", seg7, cnt_disp(43));

        // Wrap 998 -> 999 -> 000
        run_ticks(955);
        check_eq("count_998", seg7, cnt_disp(998));
        run_ticks(1);
        check_eq("count_999", seg7, cnt_disp(999));
        check_eq("digit0_nine", seg7[6:0], 7'h10);
        run_ticks(1);
        check_eq("count_wrap", seg7, cnt_disp(0));
        run_ticks(5);
        check_eq("count_005", seg7, cnt_disp(5));
        check_eq("tick_high", tick, 1'b1);

        // Async reset between edges while tick is high
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_seg", seg7, 21'h1FFFFF);
        check_eq("async_dpt", seg7_dpt, 3'b111);
        check_eq("async_tick", tick, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("post_rst_seg", seg7, cnt_disp(0));
        check_eq("post_rst_dpt", seg7_dpt, 3'b111);
        wait_tick(16, n);
        check_eq("post_rst_period", n, TD);
        check_eq("post_rst_001", seg7, cnt_disp(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
